// File: rtl/model_trainer_lstm_gradient_accumulator.sv
// LSTM trainer gradient accumulator.
// Accumulates dW = sum_t d(t) * x(t)^T over LENGTH time steps in signed fixed point
// Q(DATA_SIZE-FRACTION).FRACTION, then streams dW out row-major.
// Optional feature: define MODEL_TRAINER_LSTM_SATURATION_EN to saturate both the shifted
// product and the accumulator sum on signed overflow; otherwise arithmetic wraps.
module model_trainer_lstm_gradient_accumulator #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned FRACTION     = 32,
  parameter int unsigned X_MAX        = 8,
  parameter int unsigned L_MAX        = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_X_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_L_IN,
  input  logic [CONTROL_SIZE-1:0] LENGTH_IN,
  output logic                    X_ENABLE,
  input  logic                    X_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    X_IN,
  output logic                    D_ENABLE,
  input  logic                    D_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    D_IN,
  output logic                    DW_OUT_L_ENABLE,
  output logic                    DW_OUT_X_ENABLE,
  output logic [DATA_SIZE-1:0]    DW_OUT
);

  // Counter widths hold 0..MAX; index widths address 0..MAX-1.
  localparam int unsigned XCW = $clog2(X_MAX + 1);
  localparam int unsigned LCW = $clog2(L_MAX + 1);
  localparam int unsigned XIW = (X_MAX > 1) ? $clog2(X_MAX) : 1;
  localparam int unsigned LIW = (L_MAX > 1) ? $clog2(L_MAX) : 1;

  localparam logic [DATA_SIZE-1:0] SatMax = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] SatMin = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StLoadD,
    StAccumulate,
    StOutput
  } state_e;

  state_e                  state_q;
  logic [XCW-1:0]          size_x_q;
  logic [LCW-1:0]          size_l_q;
  logic [CONTROL_SIZE-1:0] length_q;
  logic [CONTROL_SIZE-1:0] t_q;
  logic [XCW-1:0]          i_q;
  logic [LCW-1:0]          j_q;
  logic                    zero_out_q;
  logic                    ready_q;
  logic                    x_en_q;
  logic                    d_en_q;
  logic                    dw_l_en_q;
  logic                    dw_x_en_q;
  logic [DATA_SIZE-1:0]    dw_out_q;

  logic [DATA_SIZE-1:0] x_buf [X_MAX];
  logic [DATA_SIZE-1:0] d_buf [L_MAX];
  logic [DATA_SIZE-1:0] acc   [L_MAX][X_MAX];

  logic [XCW-1:0]          size_x_clamp;
  logic [LCW-1:0]          size_l_clamp;
  logic [XCW-1:0]          i_next;
  logic [LCW-1:0]          j_next;
  logic [CONTROL_SIZE-1:0] t_next;
  logic                    x_last;
  logic                    l_last;
  logic [XIW-1:0]          i_idx;
  logic [LIW-1:0]          j_idx;

  logic signed [2*DATA_SIZE-1:0] prod_full;
  logic signed [2*DATA_SIZE-1:0] prod_shift;
  logic [DATA_SIZE-1:0]          prod_val;
  logic [DATA_SIZE-1:0]          acc_base;
  logic [DATA_SIZE-1:0]          mac_sum;

  // Clamp requested sizes to the buffer capacity.
  always_comb begin
    size_x_clamp = XCW'(X_MAX);
    size_l_clamp = LCW'(L_MAX);
    if (SIZE_X_IN <= CONTROL_SIZE'(X_MAX)) begin
      size_x_clamp = SIZE_X_IN[XCW-1:0];
    end
    if (SIZE_L_IN <= CONTROL_SIZE'(L_MAX)) begin
      size_l_clamp = SIZE_L_IN[LCW-1:0];
    end
  end

  // Counter increments and end-of-row / end-of-column detection.
  always_comb begin
    i_next = i_q + XCW'(1);
    j_next = j_q + LCW'(1);
    t_next = t_q + CONTROL_SIZE'(1);
    x_last = (i_next == size_x_q);
    l_last = (j_next == size_l_q);
    i_idx  = i_q[XIW-1:0];
    j_idx  = j_q[LIW-1:0];
  end

`ifdef MODEL_TRAINER_LSTM_SATURATION_EN
  logic [DATA_SIZE:0] sum_ext;

  // Saturating MAC: clamp the shifted product, then clamp the running sum.
  always_comb begin
    prod_full  = $signed(d_buf[j_idx]) * $signed(x_buf[i_idx]);
    prod_shift = prod_full >>> FRACTION;
    // Product fits when every bit above the result sign matches it.
    if ((&prod_shift[2*DATA_SIZE-1:DATA_SIZE-1]) || ~(|prod_shift[2*DATA_SIZE-1:DATA_SIZE-1])) begin
      prod_val = prod_shift[DATA_SIZE-1:0];
    end else if (prod_shift[2*DATA_SIZE-1]) begin
      prod_val = SatMin;
    end else begin
      prod_val = SatMax;
    end
    acc_base = (t_q == '0) ? '0 : acc[j_idx][i_idx];
    sum_ext  = {acc_base[DATA_SIZE-1], acc_base} + {prod_val[DATA_SIZE-1], prod_val};
    if (sum_ext[DATA_SIZE] == sum_ext[DATA_SIZE-1]) begin
      mac_sum = sum_ext[DATA_SIZE-1:0];
    end else if (sum_ext[DATA_SIZE]) begin
      mac_sum = SatMin;
    end else begin
      mac_sum = SatMax;
    end
  end
`else
  logic unused_prod_high;

  // Wrapping MAC: truncate the shifted product and add modulo 2^DATA_SIZE.
  always_comb begin
    prod_full  = $signed(d_buf[j_idx]) * $signed(x_buf[i_idx]);
    prod_shift = prod_full >>> FRACTION;
    prod_val   = prod_shift[DATA_SIZE-1:0];
    acc_base   = (t_q == '0) ? '0 : acc[j_idx][i_idx];
    mac_sum    = acc_base + prod_val;
  end

  // Upper product bits are discarded by truncation.
  assign unused_prod_high = ^{prod_shift[2*DATA_SIZE-1:DATA_SIZE], SatMax, SatMin};
`endif

  // Operand buffers and accumulator array; contents need no reset.
  always_ff @(posedge CLK) begin
    if (state_q == StLoadX && X_IN_ENABLE) begin
      x_buf[i_idx] <= X_IN;
    end
    if (state_q == StLoadD && D_IN_ENABLE) begin
      d_buf[j_idx] <= D_IN;
    end
    if (state_q == StAccumulate) begin
      acc[j_idx][i_idx] <= mac_sum;
    end
  end

  // Control FSM with registered handshake and output stream.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      size_x_q   <= '0;
      size_l_q   <= '0;
      length_q   <= '0;
      t_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      zero_out_q <= 1'b0;
      ready_q    <= 1'b0;
      x_en_q     <= 1'b0;
      d_en_q     <= 1'b0;
      dw_l_en_q  <= 1'b0;
      dw_x_en_q  <= 1'b0;
      dw_out_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            size_x_q   <= size_x_clamp;
            size_l_q   <= size_l_clamp;
            length_q   <= LENGTH_IN;
            t_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            zero_out_q <= (LENGTH_IN == '0);
            if (size_x_clamp == '0 || size_l_clamp == '0) begin
              // Empty matrix: finish immediately without output.
              ready_q <= 1'b1;
            end else if (LENGTH_IN == '0) begin
              state_q <= StOutput;
            end else begin
              state_q <= StLoadX;
              x_en_q  <= 1'b1;
            end
          end
        end
        StLoadX: begin
          if (X_IN_ENABLE) begin
            if (x_last) begin
              i_q     <= '0;
              x_en_q  <= 1'b0;
              d_en_q  <= 1'b1;
              state_q <= StLoadD;
            end else begin
              i_q <= i_next;
            end
          end
        end
        StLoadD: begin
          if (D_IN_ENABLE) begin
            if (l_last) begin
              j_q     <= '0;
              d_en_q  <= 1'b0;
              state_q <= StAccumulate;
            end else begin
              j_q <= j_next;
            end
          end
        end
        StAccumulate: begin
          if (x_last) begin
            i_q <= '0;
            if (l_last) begin
              j_q <= '0;
              t_q <= t_next;
              if (t_next < length_q) begin
                state_q <= StLoadX;
                x_en_q  <= 1'b1;
              end else begin
                state_q <= StOutput;
              end
            end else begin
              j_q <= j_next;
            end
          end else begin
            i_q <= i_next;
          end
        end
        StOutput: begin
          // j_q reaching size_l_q means every row has been emitted.
          if (j_q == size_l_q) begin
            dw_l_en_q <= 1'b0;
            dw_x_en_q <= 1'b0;
            ready_q   <= 1'b1;
            j_q       <= '0;
            state_q   <= StIdle;
          end else begin
            dw_x_en_q <= 1'b1;
            dw_l_en_q <= (i_q == '0);
            dw_out_q  <= zero_out_q ? '0 : acc[j_idx][i_idx];
            if (x_last) begin
              i_q <= '0;
              j_q <= j_next;
            end else begin
              i_q <= i_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign READY           = ready_q;
  assign X_ENABLE        = x_en_q;
  assign D_ENABLE        = d_en_q;
  assign DW_OUT_L_ENABLE = dw_l_en_q;
  assign DW_OUT_X_ENABLE = dw_x_en_q;
  assign DW_OUT          = dw_out_q;

endmodule

// File: tb/tb_model_trainer_lstm_gradient_accumulator.sv
// Self-checking bench for model_trainer_lstm_gradient_accumulator.
// Expected dW elements are queued when a job's stimulus is prepared and popped as the
// DUT streams them. Honours MODEL_TRAINER_LSTM_SATURATION_EN for the overflow case.
module tb_model_trainer_lstm_gradient_accumulator;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        READY;
  logic [63:0] SIZE_X_IN = '0;
  logic [63:0] SIZE_L_IN = '0;
  logic [63:0] LENGTH_IN = '0;
  logic        X_ENABLE;
  logic        X_IN_ENABLE = 1'b0;
  logic [63:0] X_IN = '0;
  logic        D_ENABLE;
  logic        D_IN_ENABLE = 1'b0;
  logic [63:0] D_IN = '0;
  logic        DW_OUT_L_ENABLE;
  logic        DW_OUT_X_ENABLE;
  logic [63:0] DW_OUT;

  model_trainer_lstm_gradient_accumulator dut (
    .CLK             (CLK),
    .RST             (RST),
    .START           (START),
    .READY           (READY),
    .SIZE_X_IN       (SIZE_X_IN),
    .SIZE_L_IN       (SIZE_L_IN),
    .LENGTH_IN       (LENGTH_IN),
    .X_ENABLE        (X_ENABLE),
    .X_IN_ENABLE     (X_IN_ENABLE),
    .X_IN            (X_IN),
    .D_ENABLE        (D_ENABLE),
    .D_IN_ENABLE     (D_IN_ENABLE),
    .D_IN            (D_IN),
    .DW_OUT_L_ENABLE (DW_OUT_L_ENABLE),
    .DW_OUT_X_ENABLE (DW_OUT_X_ENABLE),
    .DW_OUT          (DW_OUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  logic [63:0] exp_q [$];
  logic        exp_l_q [$];
  logic [63:0] xs [$];
  logic [63:0] ds [$];
  logic [63:0] xv [4][8];
  logic [63:0] dv [4][8];

  // Reference fixed-point product: full 128-bit multiply, arithmetic shift by 32.
  function automatic logic [63:0] m_prod(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    p = p >>> 32;
`ifdef MODEL_TRAINER_LSTM_SATURATION_EN
    if (p > 128'sd9223372036854775807) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (p < -128'sd9223372036854775808) return 64'h8000_0000_0000_0000;
`endif
    return p[63:0];
  endfunction

  function automatic logic [63:0] m_add(input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] s;
    s = $signed({a[63], a}) + $signed({b[63], b});
`ifdef MODEL_TRAINER_LSTM_SATURATION_EN
    if (s > 65'sd9223372036854775807) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (s < -65'sd9223372036854775808) return 64'h8000_0000_0000_0000;
`endif
    return s[63:0];
  endfunction

  task automatic load_test1();
    xv[0][0] = 64'h0000_0001_0000_0000;
    xv[0][1] = 64'h0000_0002_0000_0000;
    dv[0][0] = 64'h0000_0000_8000_0000;
    dv[0][1] = 64'hFFFF_FFFF_0000_0000;
  endtask

  task automatic push_test1_expected();
    exp_q.push_back(64'h0000_0000_8000_0000); exp_l_q.push_back(1'b1);
    exp_q.push_back(64'h0000_0001_0000_0000); exp_l_q.push_back(1'b0);
    exp_q.push_back(64'hFFFF_FFFF_0000_0000); exp_l_q.push_back(1'b1);
    exp_q.push_back(64'hFFFF_FFFE_0000_0000); exp_l_q.push_back(1'b0);
  endtask

  task automatic fill_feed(input int sx, input int sl, input int len);
    xs.delete();
    ds.delete();
    for (int t = 0; t < len; t++) begin
      for (int i = 0; i < sx; i++) xs.push_back(xv[t][i]);
      for (int j = 0; j < sl; j++) ds.push_back(dv[t][j]);
    end
  endtask

  task automatic pulse_start(input int sx, input int sl, input int len);
    @(negedge CLK);
    SIZE_X_IN = 64'(sx);
    SIZE_L_IN = 64'(sl);
    LENGTH_IN = 64'(len);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Runs one job from START to READY, scoring every streamed element.
  task automatic run_job(input string name, input int sx, input int sl, input int len,
                         input bit use_model, input int gap, input bit spur,
                         input bit mid_start);
    int cyc;
    int nout;
    int expn;
    bit done;
    bit prev_out;
    logic [63:0] a;
    logic [63:0] e;
    logic        el;
    logic [63:0] last;
    if (use_model && sx > 0 && sl > 0) begin
      for (int j = 0; j < sl; j++) begin
        for (int i = 0; i < sx; i++) begin
          a = '0;
          for (int t = 0; t < len; t++) a = m_add(a, m_prod(dv[t][j], xv[t][i]));
          exp_q.push_back(a);
          exp_l_q.push_back(i == 0);
        end
      end
    end
    expn = exp_q.size();
    fill_feed(sx, sl, len);
    pulse_start(sx, sl, len);
    cyc = 0; nout = 0; done = 1'b0; prev_out = 1'b0; last = '0;
    while (!done && cyc < 3000) begin
      if (READY) begin
        done = 1'b1;
        total++;
        if (exp_q.size() != 0 || (expn > 0 && !prev_out) || (expn == 0 && cyc != 0)) begin
          bad++;
          $display("FAIL %s ready_timing: got cycle %0d left %0d want right after last", name,
                   cyc, exp_q.size());
        end
        total++;
        if ({X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE} !== 4'b0) begin
          bad++;
          $display("FAIL %s enables_at_ready: got %b want 0000", name,
                   {X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE});
        end
        if (expn > 0) begin
          total++;
          if (DW_OUT !== last) begin
            bad++;
            $display("FAIL %s dw_hold: got %h want %h", name, DW_OUT, last);
          end
        end
      end
      if (DW_OUT_X_ENABLE) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL %s extra_dw: got %h want none", name, DW_OUT);
        end else begin
          e = exp_q.pop_front();
          el = exp_l_q.pop_front();
          total++;
          if (DW_OUT !== e) begin
            bad++;
            $display("FAIL %s dw[%0d]: got %h want %h", name, nout, DW_OUT, e);
          end
          total++;
          if (DW_OUT_L_ENABLE !== el) begin
            bad++;
            $display("FAIL %s l_en[%0d]: got %b want %b", name, nout, DW_OUT_L_ENABLE, el);
          end
        end
        last = DW_OUT;
        nout++;
      end
      prev_out = DW_OUT_X_ENABLE;
      X_IN_ENABLE = 1'b0;
      D_IN_ENABLE = 1'b0;
      START = 1'b0;
      if (X_ENABLE && (cyc % gap == 0) && xs.size() > 0) begin
        X_IN_ENABLE = 1'b1;
        X_IN = xs.pop_front();
      end else if (X_ENABLE && spur) begin
        D_IN_ENABLE = 1'b1;
        D_IN = 64'h7777_7777_7777_7777;
      end
      if (D_ENABLE && (cyc % gap == 0) && ds.size() > 0) begin
        D_IN_ENABLE = 1'b1;
        D_IN = ds.pop_front();
      end
      if (mid_start && (cyc == 3 || cyc == 9)) begin
        START = 1'b1;
        SIZE_X_IN = 64'd1;
        SIZE_L_IN = 64'd1;
        LENGTH_IN = 64'd0;
      end
      cyc++;
      if (!done) @(negedge CLK);
    end
    X_IN_ENABLE = 1'b0;
    D_IN_ENABLE = 1'b0;
    START = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: got no READY want READY", name);
    end
    total++;
    if (nout != expn) begin
      bad++;
      $display("FAIL %s count: got %0d want %0d", name, nout, expn);
    end
    exp_q.delete();
    exp_l_q.delete();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({READY, X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {READY, X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE});
    end
    total++;
    if (DW_OUT !== 64'h0) begin
      bad++;
      $display("FAIL reset_dw: got %h want 0", DW_OUT);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_basic();
    load_test1();
    push_test1_expected();
    run_job("basic", 2, 2, 1, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_accumulate();
    for (int t = 0; t < 3; t++) begin
      xv[t][0] = 64'h0000_0001_0000_0000;
      dv[t][0] = 64'h0000_0001_0000_0000;
    end
    exp_q.push_back(64'h0000_0003_0000_0000);
    exp_l_q.push_back(1'b1);
    run_job("accum", 1, 1, 3, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_gapped();
    load_test1();
    push_test1_expected();
    run_job("gapped", 2, 2, 1, 1'b0, 3, 1'b1, 1'b0);
  endtask

  task automatic test_degenerate();
    run_job("len0", 2, 2, 0, 1'b1, 1, 1'b0, 1'b0);
    run_job("sizex0", 0, 2, 1, 1'b1, 1, 1'b0, 1'b0);
    run_job("sizel0", 3, 0, 2, 1'b1, 1, 1'b0, 1'b0);
    load_test1();
    run_job("mid_start", 2, 2, 1, 1'b1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) begin
        xv[t][k] = {{30{1'b0}}, 34'($urandom)} - 64'h0000_0001_0000_0000;
        dv[t][k] = {{30{1'b0}}, 34'($urandom)} - 64'h0000_0001_0000_0000;
      end
    end
    run_job("random", 3, 4, 3, 1'b1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    xv[0][0] = 64'h0010_0000_0000_0000;
    dv[0][0] = 64'h0010_0000_0000_0000;
`ifdef MODEL_TRAINER_LSTM_SATURATION_EN
    exp_q.push_back(64'h7FFF_FFFF_FFFF_FFFF);
`else
    exp_q.push_back(64'h0000_0000_0000_0000);
`endif
    exp_l_q.push_back(1'b1);
    run_job("overflow", 1, 1, 1, 1'b0, 1, 1'b0, 1'b0);
  endtask

  // Feeds a test-1 job until ACCUMULATE (mode 0) or the first dW element (mode 1).
  task automatic feed_until(input int mode, output bit hit);
    int cyc;
    bit seen_d;
    load_test1();
    fill_feed(2, 2, 1);
    pulse_start(2, 2, 1);
    hit = 1'b0; seen_d = 1'b0; cyc = 0;
    while (!hit && cyc < 200) begin
      if (mode == 0 && D_ENABLE) seen_d = 1'b1;
      if (mode == 0 && !D_ENABLE && seen_d) hit = 1'b1;
      if (mode == 1 && DW_OUT_X_ENABLE) hit = 1'b1;
      X_IN_ENABLE = 1'b0;
      D_IN_ENABLE = 1'b0;
      if (!hit) begin
        if (X_ENABLE && xs.size() > 0) begin X_IN_ENABLE = 1'b1; X_IN = xs.pop_front(); end
        if (D_ENABLE && ds.size() > 0) begin D_IN_ENABLE = 1'b1; D_IN = ds.pop_front(); end
        cyc++;
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit hit;
    int stray;
    feed_until(0, hit);
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rst_mid reach_accumulate: got timeout want accumulate");
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if ({READY, X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE, DW_OUT} !== 69'b0) begin
      bad++;
      $display("FAIL rst_mid accum_outputs: got %b/%h want all zero",
               {READY, X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE}, DW_OUT);
    end
    @(negedge CLK);
    RST = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (READY || X_ENABLE || D_ENABLE || DW_OUT_X_ENABLE) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL rst_mid idle_after: got %0d active cycles want 0", stray);
    end
    feed_until(1, hit);
    total++;
    if (!hit || DW_OUT !== 64'h0000_0000_8000_0000) begin
      bad++;
      $display("FAIL rst_mid reach_output: got %h want 0000000080000000", DW_OUT);
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if ({READY, X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE, DW_OUT} !== 69'b0) begin
      bad++;
      $display("FAIL rst_mid output_outputs: got %b/%h want all zero",
               {READY, X_ENABLE, D_ENABLE, DW_OUT_L_ENABLE, DW_OUT_X_ENABLE}, DW_OUT);
    end
    @(negedge CLK);
    RST = 1'b1;
    load_test1();
    push_test1_expected();
    run_job("after_reset", 2, 2, 1, 1'b0, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_gapped();
    test_degenerate();
    test_overflow();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
